banco_registros_param: RTL

- Parametrised successor to the 32-entry read-select path: a register bank with DEPTH = 2**ADDR_W entries of DATA_W bits.
- Provides NUM_RD independent combinational read ports and one synchronous write port.
- Adds an optional hard-wired zero entry and a handshaked sequential dump engine that streams every entry to the debug unit.
- Sits in the decode stage of the pipelined processor; the dump port feeds the UART debug unit.

---
 rtl/banco_registros_param.sv | 107 ++++++++++
 1 files changed

// File: rtl/banco_registros_param.sv
// Parametrised register bank with NUM_RD combinational read ports, one write port
// and a handshaked dump engine. Define BANCO_REGISTROS_BYPASS_EN for write-through forwarding.
module banco_registros_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     dump_start,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done,
    output logic                     dump_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (wr_en && wr_addr == a) v = wr_data;
`endif
        // The hard-wired zero wins over forwarding.
        if (ZERO_REG != 0 && a == '0) v = '0;
        return v;
    endfunction

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = read_entry(rd_addr[k*ADDR_W +: ADDR_W]);
        end
        dump_data = read_entry(idx_q);
    end

    // NOTE: the bank must read all-zero during reset, so every entry is reset here;
    // this rules out mapping the array onto a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: next-state values get defaults first so no path leaves them unassigned (no latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
                    else                             idx_d   = idx_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_idx   = idx_q;
    assign dump_valid = (state_q == SEND);
    assign dump_done  = (state_q == DONE);
    assign dump_busy  = (state_q != IDLE);

endmodule
